// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier producing a 2*WIDTH-bit two's complement product.
// Optional MULT_SIGNED_SEL_EN adds an is_signed input selecting signed (MULT) or unsigned (MULTU).
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
`ifdef MULT_SIGNED_SEL_EN
  input  logic                 is_signed,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic                 sign_q, sign_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 signed_op;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   raw;

`ifdef MULT_SIGNED_SEL_EN
  assign signed_op = is_signed;
`else
  assign signed_op = 1'b1;
`endif

  // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    a_neg = signed_op & multiplicand[WIDTH-1];
    b_neg = signed_op & multiplier[WIDTH-1];
    a_mag = a_neg ? (~multiplicand + WIDTH'(1)) : multiplicand;
    b_mag = b_neg ? (~multiplier + WIDTH'(1)) : multiplier;
    sum   = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    raw   = {acc_q, mplr_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplr_q    <= '0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      sign_q    <= sign_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // CALC runs WIDTH shift-add steps, then one extra edge registers the signed result.
  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    sign_d    = sign_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a_mag;
          mplr_d  = b_mag;
          sign_d  = a_neg ^ b_neg;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
        end
      end
      S_CALC: begin
        if (cnt_q != '0) begin
          acc_d  = sum[WIDTH:1];
          mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
          cnt_d  = cnt_q - CW'(1);
        end else begin
          product_d = sign_q ? (~raw + (2*WIDTH)'(1)) : raw;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    product = product_q;
  end

endmodule
